voice_allocator: RTL

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator_if.sv | 26 ++
 rtl/voice_allocator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator_if
// Description : Note-event handshake bundle between an event source and the
//               voice allocator.
// Revision    : 1.0 - initial release
// ============================================================================
interface voice_allocator_if;
    logic        evValid;
    logic        evReady;
    logic        evNoteOn;
    logic [6:0]  evKey;
    logic [15:0] evTuneWord;
    logic [7:0]  evVolume;

    modport master (
        output evValid, evNoteOn, evKey, evTuneWord, evVolume,
        input  evReady
    );

    modport slave (
        input  evValid, evNoteOn, evKey, evTuneWord, evVolume,
        output evReady
    );
endinterface
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Polyphonic voice allocator with retrigger, idle, release and
//               oldest-held steal selection plus tick-driven release decay.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int         NUM_TRACKS   = 4,
    parameter logic [7:0] RELEASE_STEP = 8'd4
) (
    input  logic                     clk,
    input  logic                     reset,
    voice_allocator_if.slave         ev,
    input  logic                     tick,
    output logic [NUM_TRACKS*24-1:0] notePackets,
    output logic [NUM_TRACKS-1:0]    voiceActive,
    output logic                     stealPulse
);
    localparam int IW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;

    typedef enum logic [1:0] {V_IDLE = 2'd0, V_HELD = 2'd1, V_REL = 2'd2} vstate_t;
    typedef enum logic [0:0] {S_ACCEPT = 1'b0, S_APPLY = 1'b1} fsm_t;

    fsm_t        fsm_q;
    logic        ready_q;
    logic        evt_on_q;
    logic [6:0]  evt_key_q;
    logic [15:0] evt_tune_q;
    logic [7:0]  evt_vol_q;

    vstate_t     st_q   [NUM_TRACKS];
    vstate_t     st_d   [NUM_TRACKS];
    logic [6:0]  key_q  [NUM_TRACKS];
    logic [6:0]  key_d  [NUM_TRACKS];
    logic [15:0] tune_q [NUM_TRACKS];
    logic [15:0] tune_d [NUM_TRACKS];
    logic [7:0]  vol_q  [NUM_TRACKS];
    logic [7:0]  vol_d  [NUM_TRACKS];
    logic [3:0]  age_q  [NUM_TRACKS];
    logic [3:0]  age_d  [NUM_TRACKS];

    logic [NUM_TRACKS*24-1:0] pkt_q;
    logic [NUM_TRACKS-1:0]    act_q;
    logic                     steal_q;

    logic          match_hit, idle_hit, rel_hit, held_hit, off_hit;
    logic [IW-1:0] match_idx, idle_idx, rel_idx, held_idx, off_idx, sel_idx;
    logic [7:0]    rel_vol;
    logic [3:0]    held_age;
    logic          sel_steal;
    logic          apply;

    assign apply = (fsm_q == S_APPLY);

    // Candidate scans; strict compares keep ties on the lowest index.
    always_comb begin
        match_hit = 1'b0; match_idx = '0;
        idle_hit  = 1'b0; idle_idx  = '0;
        rel_hit   = 1'b0; rel_idx   = '0; rel_vol  = '0;
        held_hit  = 1'b0; held_idx  = '0; held_age = '0;
        off_hit   = 1'b0; off_idx   = '0;
        for (int v = 0; v < NUM_TRACKS; v++) begin
            if (!match_hit && st_q[v] != V_IDLE && key_q[v] == evt_key_q) begin
                match_hit = 1'b1; match_idx = IW'(v);
            end
            if (!off_hit && st_q[v] == V_HELD && key_q[v] == evt_key_q) begin
                off_hit = 1'b1; off_idx = IW'(v);
            end
            if (!idle_hit && st_q[v] == V_IDLE) begin
                idle_hit = 1'b1; idle_idx = IW'(v);
            end
            if (st_q[v] == V_REL && (!rel_hit || vol_q[v] < rel_vol)) begin
                rel_hit = 1'b1; rel_idx = IW'(v); rel_vol = vol_q[v];
            end
            if (st_q[v] == V_HELD && (!held_hit || age_q[v] > held_age)) begin
                held_hit = 1'b1; held_idx = IW'(v); held_age = age_q[v];
            end
        end
        sel_steal = 1'b0;
        if (match_hit)     sel_idx = match_idx;
        else if (idle_hit) sel_idx = idle_idx;
        else if (rel_hit)  sel_idx = rel_idx;
        else begin
            sel_idx   = held_idx;
            sel_steal = 1'b1;
        end
    end

    // Tick decay first; an APPLY write to the same voice overrides it.
    always_comb begin
        for (int v = 0; v < NUM_TRACKS; v++) begin
            st_d[v]   = st_q[v];
            key_d[v]  = key_q[v];
            tune_d[v] = tune_q[v];
            vol_d[v]  = vol_q[v];
            age_d[v]  = age_q[v];
            if (tick && st_q[v] == V_REL) begin
                vol_d[v] = (vol_q[v] > RELEASE_STEP) ? vol_q[v] - RELEASE_STEP : 8'd0;
                if (vol_q[v] <= RELEASE_STEP) st_d[v] = V_IDLE;
            end
            if (apply) begin
                if (evt_on_q) begin
                    if (IW'(v) == sel_idx) begin
                        st_d[v]   = V_HELD;
                        key_d[v]  = evt_key_q;
                        tune_d[v] = evt_tune_q;
                        vol_d[v]  = evt_vol_q;
                        age_d[v]  = 4'd0;
                    end else if (st_q[v] != V_IDLE && age_q[v] != 4'hF) begin
                        age_d[v] = age_q[v] + 4'd1;
                    end
                end else if (off_hit && IW'(v) == off_idx) begin
                    st_d[v] = V_REL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q      <= S_ACCEPT;
            ready_q    <= 1'b0;
            evt_on_q   <= 1'b0;
            evt_key_q  <= '0;
            evt_tune_q <= '0;
            evt_vol_q  <= '0;
            pkt_q      <= '0;
            act_q      <= '0;
            steal_q    <= 1'b0;
            for (int v = 0; v < NUM_TRACKS; v++) begin
                st_q[v]   <= V_IDLE;
                key_q[v]  <= '0;
                tune_q[v] <= '0;
                vol_q[v]  <= '0;
                age_q[v]  <= '0;
            end
        end else begin
            case (fsm_q)
                S_ACCEPT: begin
                    if (ev.evValid && ready_q) begin
                        evt_on_q   <= ev.evNoteOn && (ev.evVolume != 8'd0);
                        evt_key_q  <= ev.evKey;
                        evt_tune_q <= ev.evTuneWord;
                        evt_vol_q  <= ev.evVolume;
                        fsm_q      <= S_APPLY;
                        ready_q    <= 1'b0;
                    end else begin
                        ready_q    <= 1'b1;
                    end
                end
                default: begin
                    fsm_q   <= S_ACCEPT;
                    ready_q <= 1'b1;
                end
            endcase
            steal_q <= apply && evt_on_q && sel_steal;
            // Output stage registers the voice state, one edge behind it.
            for (int v = 0; v < NUM_TRACKS; v++) begin
                pkt_q[24*v +: 24] <= (st_q[v] == V_IDLE) ? 24'h0 : {tune_q[v], vol_q[v]};
                act_q[v]          <= (st_q[v] != V_IDLE);
                st_q[v]   <= st_d[v];
                key_q[v]  <= key_d[v];
                tune_q[v] <= tune_d[v];
                vol_q[v]  <= vol_d[v];
                age_q[v]  <= age_d[v];
            end
        end
    end

    assign ev.evReady  = ready_q;
    assign notePackets = pkt_q;
    assign voiceActive = act_q;
    assign stealPulse  = steal_q;
endmodule
`default_nettype wire
